// File: rtl/icache_pkg.sv
// icache_pkg: shared types and constants for the direct-mapped instruction cache.
// Holds the line geometry, the controller FSM state encoding and a word-select helper.
package icache_pkg;

   localparam int LINE_W         = 128;
   localparam int WORDS_PER_LINE = 4;
   localparam int OFFS_W         = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } icache_state_e;

   typedef logic [LINE_W-1:0] cache_line_t;

   // Pick 32-bit word 'offs' out of a line (word k lives at bits [32k+31:32k]).
   function automatic logic [31:0] line_word(input cache_line_t line,
                                             input logic [OFFS_W-1:0] offs);
      return line[{offs, 5'b00000} +: 32];
   endfunction

endpackage

// File: rtl/icache_array.sv
// icache_array: valid/tag/data storage for the direct-mapped instruction cache.
// One asynchronous read port (lookup index) and one synchronous write port (line fill).
// Only the valid bits are reset; tag and data contents are meaningless until a fill.
module icache_array
   import icache_pkg::*;
#(
   parameter int LINES = 16,
   parameter int IDX_W = 4,
   parameter int TAG_W = 24
) (
   input  logic              clk,
   input  logic              rst_n,
   // lookup port
   input  logic [IDX_W-1:0]  rd_idx,
   output logic              rd_valid,
   output logic [TAG_W-1:0]  rd_tag,
   output cache_line_t       rd_line,
   // fill port
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [TAG_W-1:0]  wr_tag,
   input  cache_line_t       wr_line
);

   logic              valid_reg [LINES];
   logic [TAG_W-1:0]  tag_arr   [LINES];
   cache_line_t       data_arr  [LINES];

   // One valid flop per line: cleared by reset, set when that line is filled.
   for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            valid_reg[gi] <= 1'b0;
         end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
            valid_reg[gi] <= 1'b1;
         end
      end
   end

   // Tag and data storage: written on a fill, never reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_arr[wr_idx]  <= wr_tag;
         data_arr[wr_idx] <= wr_line;
      end
   end

   // Asynchronous read so a hit can be answered in the same cycle.
   always_comb begin
      rd_valid = valid_reg[rd_idx];
      rd_tag   = tag_arr[rd_idx];
      rd_line  = data_arr[rd_idx];
   end

endmodule

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped read-only instruction cache in front of a 128-bit
// line-fill controller. Hits answer combinationally; a miss issues one line
// request, waits for the response, fills the line and returns to lookup.
// Optional hit/miss counters are built only when ICACHE_PERF_CNT_EN is defined;
// otherwise hit_cnt_o and miss_cnt_o are tied to zero.
module icache_dm
   import icache_pkg::*;
#(
   parameter int LINES = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   // CPU fetch port
   input  logic          cpu_req_i,
   input  logic [31:0]   cpu_addr_i,
   output logic          cpu_rdy_o,
   output logic [31:0]   cpu_data_o,
   // line-fill controller port
   output logic          mem_req_o,
   output logic [31:0]   mem_addr_o,
   input  logic          mem_rsp_i,
   input  logic [127:0]  mem_data_i,
   // performance counters
   output logic [31:0]   hit_cnt_o,
   output logic [31:0]   miss_cnt_o
);

   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = 32 - 4 - IDX_W;

   icache_state_e        state_reg, state_next;
   logic [27:0]          miss_line_reg;   // addr[31:4] of the outstanding miss

   logic [IDX_W-1:0]     req_idx;
   logic [TAG_W-1:0]     req_tag;
   logic [OFFS_W-1:0]    req_offs;
   logic [IDX_W-1:0]     miss_idx;
   logic [TAG_W-1:0]     miss_tag;

   logic                 rd_valid;
   logic [TAG_W-1:0]     rd_tag;
   cache_line_t          rd_line;

   logic                 lookup_hit;
   logic                 hit;
   logic                 miss_start;
   logic                 fill_en;
   logic                 line_req;

   // Byte-offset bits never select anything in a word-wide fetch.
   logic                 unused_addr_bits;
   assign unused_addr_bits = &{1'b0, cpu_addr_i[1:0]};

   // Split the fetch address and the latched miss address into index/tag/offset.
   always_comb begin
      req_offs = cpu_addr_i[3:2];
      req_idx  = cpu_addr_i[4 +: IDX_W];
      req_tag  = cpu_addr_i[31 -: TAG_W];
      miss_idx = miss_line_reg[IDX_W-1:0];
      miss_tag = miss_line_reg[27 -: TAG_W];
   end

   icache_array #(
      .LINES (LINES),
      .IDX_W (IDX_W),
      .TAG_W (TAG_W)
   ) u_array (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_idx   (req_idx),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .rd_line  (rd_line),
      .wr_en    (fill_en),
      .wr_idx   (miss_idx),
      .wr_tag   (miss_tag),
      .wr_line  (mem_data_i)
   );

   // Tag compare on the lookup index.
   always_comb begin
      lookup_hit = cpu_req_i && rd_valid && (rd_tag == req_tag);
   end

   // FSM state register; reset aborts any miss in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next state and per-state control strobes.
   always_comb begin
      state_next = state_reg;
      hit        = 1'b0;
      miss_start = 1'b0;
      fill_en    = 1'b0;
      line_req   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (cpu_req_i) begin
               if (lookup_hit) begin
                  hit = 1'b1;
               end else begin
                  miss_start = 1'b1;
                  state_next = REQ;
               end
            end
         end
         REQ: begin
            line_req   = 1'b1;
            state_next = WAIT;
         end
         WAIT: begin
            // mem_data_i only matters in the cycle the response is valid.
            if (mem_rsp_i) begin
               fill_en    = 1'b1;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Latch the line address of a miss; the fill always targets this address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         miss_line_reg <= '0;
      end else if (miss_start) begin
         miss_line_reg <= cpu_addr_i[31:4];
      end
   end

   // CPU and controller outputs; data comes straight from the array, ungated.
   always_comb begin
      cpu_rdy_o  = hit;
      cpu_data_o = line_word(rd_line, req_offs);
      mem_req_o  = line_req;
      mem_addr_o = line_req ? {2'b00, miss_line_reg, 2'b00} : 32'd0;
   end

`ifdef ICACHE_PERF_CNT_EN
   logic [31:0] hit_cnt_reg;
   logic [31:0] miss_cnt_reg;

   // Count hit cycles and miss starts; both wrap naturally at 2^32.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt_reg  <= '0;
         miss_cnt_reg <= '0;
      end else begin
         if (hit) begin
            hit_cnt_reg <= hit_cnt_reg + 32'd1;
         end
         if (miss_start) begin
            miss_cnt_reg <= miss_cnt_reg + 32'd1;
         end
      end
   end

   assign hit_cnt_o  = hit_cnt_reg;
   assign miss_cnt_o = miss_cnt_reg;
`else
   assign hit_cnt_o  = 32'd0;
   assign miss_cnt_o = 32'd0;
`endif

endmodule
